// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: elastic pipeline-stage register with a 2-entry skid buffer.
// Carries a control bundle, an instruction word and an opaque payload over a
// valid/ready handshake. Ready toward upstream is registered, so downstream
// back-pressure never forms a combinational path through this stage.
// A bubble (reset, flush or empty stage) shows all-zero control and NOP_INSTR.
// Optional build macro: PIPE_SKID_STAGE_STATS_EN adds stall/flush counters.
module pipe_skid_stage #(
    parameter int                 CTRL_W    = 8,
    parameter int                 INSTR_W   = 32,
    parameter int                 DATA_W    = 96,
    parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h00000013
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    input  logic               s_valid_i,
    output logic               s_ready_o,
    input  logic [CTRL_W-1:0]  s_ctrl_i,
    input  logic [INSTR_W-1:0] s_instr_i,
    input  logic [DATA_W-1:0]  s_data_i,
    output logic               m_valid_o,
    input  logic               m_ready_i,
    output logic [CTRL_W-1:0]  m_ctrl_o,
    output logic [INSTR_W-1:0] m_instr_o,
    output logic [DATA_W-1:0]  m_data_o
`ifdef PIPE_SKID_STAGE_STATS_EN
    ,
    output logic [15:0]        stall_cnt_o,
    output logic [15:0]        flush_cnt_o
`endif
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t               r_state;
    logic                 r_mValid;
    logic                 r_sReady;
    logic [CTRL_W-1:0]    r_mainCtrl;
    logic [INSTR_W-1:0]   r_mainInstr;
    logic [DATA_W-1:0]    r_mainData;
    logic [CTRL_W-1:0]    r_skidCtrl;
    logic [INSTR_W-1:0]   r_skidInstr;
    logic [DATA_W-1:0]    r_skidData;

    logic                 w_accept;
    logic                 w_drain;

    assign w_accept  = s_valid_i & r_sReady;
    assign w_drain   = r_mValid & m_ready_i;

    assign s_ready_o = r_sReady;
    assign m_valid_o = r_mValid;
    assign m_ctrl_o  = r_mainCtrl;
    assign m_instr_o = r_mainInstr;
    assign m_data_o  = r_mainData;

    // Occupancy FSM; main register always holds the bubble pattern when empty,
    // so outputs come straight from flops. Reset and flush both force a bubble.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_state     <= S_EMPTY;
            r_mValid    <= 1'b0;
            r_sReady    <= 1'b1;
            r_mainCtrl  <= '0;
            r_mainInstr <= NOP_INSTR;
            r_mainData  <= '0;
            r_skidCtrl  <= '0;
            r_skidInstr <= NOP_INSTR;
            r_skidData  <= '0;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_accept) begin
                        r_state     <= S_ONE;
                        r_mValid    <= 1'b1;
                        r_mainCtrl  <= s_ctrl_i;
                        r_mainInstr <= s_instr_i;
                        r_mainData  <= s_data_i;
                    end
                end
                S_ONE: begin
                    if (w_accept && w_drain) begin
                        r_mainCtrl  <= s_ctrl_i;
                        r_mainInstr <= s_instr_i;
                        r_mainData  <= s_data_i;
                    end else if (w_accept) begin
                        r_state     <= S_TWO;
                        r_sReady    <= 1'b0;
                        r_skidCtrl  <= s_ctrl_i;
                        r_skidInstr <= s_instr_i;
                        r_skidData  <= s_data_i;
                    end else if (w_drain) begin
                        r_state     <= S_EMPTY;
                        r_mValid    <= 1'b0;
                        r_mainCtrl  <= '0;
                        r_mainInstr <= NOP_INSTR;
                    end
                end
                S_TWO: begin
                    if (w_drain) begin
                        r_state     <= S_ONE;
                        r_sReady    <= 1'b1;
                        r_mainCtrl  <= r_skidCtrl;
                        r_mainInstr <= r_skidInstr;
                        r_mainData  <= r_skidData;
                    end
                end
                default: begin
                    r_state     <= S_EMPTY;
                    r_mValid    <= 1'b0;
                    r_sReady    <= 1'b1;
                    r_mainCtrl  <= '0;
                    r_mainInstr <= NOP_INSTR;
                end
            endcase
        end
    end

`ifdef PIPE_SKID_STAGE_STATS_EN
    logic [15:0] r_stallCnt;
    logic [15:0] r_flushCnt;

    assign stall_cnt_o = r_stallCnt;
    assign flush_cnt_o = r_flushCnt;

    // Saturating stall and flush counters; only reset clears them.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stallCnt <= '0;
            r_flushCnt <= '0;
        end else begin
            if (r_mValid && !m_ready_i && (r_stallCnt != 16'hFFFF)) begin
                r_stallCnt <= r_stallCnt + 16'd1;
            end
            if (flush_i && r_mValid && (r_flushCnt != 16'hFFFF)) begin
                r_flushCnt <= r_flushCnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb_pipe_skid_stage: directed and randomised checks of pipe_skid_stage
// against a queue-based model of a 2-deep FIFO stage.
module tb_pipe_skid_stage;

    localparam int          CTRL_W  = 8;
    localparam int          INSTR_W = 32;
    localparam int          DATA_W  = 96;
    localparam logic [31:0] NOP     = 32'h00000013;

    typedef struct packed {
        logic [CTRL_W-1:0]  ctrl;
        logic [INSTR_W-1:0] instr;
        logic [DATA_W-1:0]  data;
    } entry_t;

    logic               clk_i = 1'b0;
    logic               rst_i = 1'b1;
    logic               flush_i = 1'b0;
    logic               s_valid_i = 1'b0;
    logic               s_ready_o;
    logic [CTRL_W-1:0]  s_ctrl_i = '0;
    logic [INSTR_W-1:0] s_instr_i = '0;
    logic [DATA_W-1:0]  s_data_i = '0;
    logic               m_valid_o;
    logic               m_ready_i = 1'b0;
    logic [CTRL_W-1:0]  m_ctrl_o;
    logic [INSTR_W-1:0] m_instr_o;
    logic [DATA_W-1:0]  m_data_o;
`ifdef PIPE_SKID_STAGE_STATS_EN
    logic [15:0]        stall_cnt_o;
    logic [15:0]        flush_cnt_o;
`endif

    int checks = 0;
    int errors = 0;
    bit compareEn = 1'b0;

    entry_t             modelQ[$];
    logic [DATA_W-1:0]  modelLastData = '0;
    int                 accCount = 0;
    logic [31:0]        dutEmitted[$];
    bit                 mAcc;
    bit                 mDrn;
    logic [CTRL_W-1:0]  expCtrl;
    logic [INSTR_W-1:0] expInstr;
    logic [DATA_W-1:0]  expData;
`ifdef PIPE_SKID_STAGE_STATS_EN
    int                 expStall = 0;
    int                 expFlush = 0;
`endif

    pipe_skid_stage dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .flush_i   (flush_i),
        .s_valid_i (s_valid_i),
        .s_ready_o (s_ready_o),
        .s_ctrl_i  (s_ctrl_i),
        .s_instr_i (s_instr_i),
        .s_data_i  (s_data_i),
        .m_valid_o (m_valid_o),
        .m_ready_i (m_ready_i),
        .m_ctrl_o  (m_ctrl_o),
        .m_instr_o (m_instr_o),
        .m_data_o  (m_data_o)
`ifdef PIPE_SKID_STAGE_STATS_EN
        ,
        .stall_cnt_o (stall_cnt_o),
        .flush_cnt_o (flush_cnt_o)
`endif
    );

    // Free-running clock, 10 time units per period.
    always #5 clk_i = ~clk_i;

    function automatic entry_t makeEntry(input logic [31:0] instr);
        entry_t e;
        e.ctrl  = instr[7:0] ^ 8'h5A;
        e.instr = instr;
        e.data  = {instr ^ 32'hDEADBEEF, ~instr, instr};
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, then wait until the following falling edge.
    task automatic applyStimulus(input logic v, input logic [31:0] instr,
                                 input logic mr, input logic fl, input logic rs);
        entry_t e;
        e         = makeEntry(instr);
        s_valid_i = v;
        s_ctrl_i  = e.ctrl;
        s_instr_i = e.instr;
        s_data_i  = e.data;
        m_ready_i = mr;
        flush_i   = fl;
        rst_i     = rs;
        @(negedge clk_i);
    endtask

    // Reference model: the stage behaves as a FIFO of depth two whose ready
    // reflects occupancy before the edge; also logs what the DUT hands off.
    always @(posedge clk_i) begin
        mAcc = s_valid_i && (modelQ.size() < 2);
        mDrn = (modelQ.size() > 0) && m_ready_i;
        if (!rst_i && m_valid_o === 1'b1 && m_ready_i) begin
            dutEmitted.push_back(m_instr_o);
        end
`ifdef PIPE_SKID_STAGE_STATS_EN
        if (rst_i) begin
            expStall = 0;
            expFlush = 0;
        end else begin
            if (modelQ.size() > 0 && !m_ready_i && expStall < 65535) expStall++;
            if (flush_i && modelQ.size() > 0 && expFlush < 65535) expFlush++;
        end
`endif
        if (rst_i || flush_i) begin
            modelQ.delete();
            modelLastData = '0;
        end else begin
            if (mDrn) void'(modelQ.pop_front());
            if (mAcc) begin
                modelQ.push_back('{ctrl: s_ctrl_i, instr: s_instr_i, data: s_data_i});
                accCount++;
            end
            if (modelQ.size() > 0) modelLastData = modelQ[0].data;
        end
    end

    // Compare every DUT output against the model on each falling edge.
    always @(negedge clk_i) begin
        if (compareEn) begin
            if (modelQ.size() > 0) begin
                expCtrl  = modelQ[0].ctrl;
                expInstr = modelQ[0].instr;
                expData  = modelQ[0].data;
            end else begin
                expCtrl  = '0;
                expInstr = NOP;
                expData  = modelLastData;
            end
            checkOutput("s_ready", s_ready_o, (modelQ.size() < 2));
            checkOutput("m_valid", m_valid_o, (modelQ.size() > 0));
            checkOutput("m_ctrl", m_ctrl_o, expCtrl);
            checkOutput("m_instr", m_instr_o, expInstr);
            checkOutput("m_data", m_data_o, expData);
`ifdef PIPE_SKID_STAGE_STATS_EN
            checkOutput("stall_cnt", stall_cnt_o, expStall[15:0]);
            checkOutput("flush_cnt", flush_cnt_o, expFlush[15:0]);
`endif
        end
    end

    initial begin
        int cyc;
        int base;

        // Reset held two cycles while upstream offers an entry.
        applyStimulus(1'b1, 32'h55, 1'b1, 1'b0, 1'b1);
        compareEn = 1'b1;
        applyStimulus(1'b1, 32'h55, 1'b1, 1'b0, 1'b1);
        checkOutput("rst_valid", m_valid_o, 1'b0);
        checkOutput("rst_instr", m_instr_o, 32'h00000013);
        checkOutput("rst_ctrl", m_ctrl_o, 8'h00);
        checkOutput("rst_ready", s_ready_o, 1'b1);
        checkOutput("rst_data", m_data_o, 96'h0);

        // Streaming with downstream always ready.
        dutEmitted.delete();
        applyStimulus(1'b1, 32'h100, 1'b1, 1'b0, 1'b0);
        checkOutput("lat1_valid", m_valid_o, 1'b1);
        checkOutput("lat1_instr", m_instr_o, 32'h100);
        checkOutput("lat1_ctrl", m_ctrl_o, 8'h5A);
        for (int i = 1; i < 8; i++) begin
            applyStimulus(1'b1, 32'h100 + i, 1'b1, 1'b0, 1'b0);
        end
        checkOutput("stream_ready", s_ready_o, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("stream_count", dutEmitted.size(), 8);
        for (int i = 0; i < 8 && i < dutEmitted.size(); i++) begin
            checkOutput("stream_order", dutEmitted[i], 32'h100 + i);
        end

        // Back-pressure fills main then skid; upstream then sees not-ready.
        dutEmitted.delete();
        applyStimulus(1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h201, 1'b0, 1'b0, 1'b0);
        checkOutput("bp_ready_low", s_ready_o, 1'b0);
        applyStimulus(1'b1, 32'h202, 1'b0, 1'b0, 1'b0);
        checkOutput("bp_hold_instr", m_instr_o, 32'h200);
        checkOutput("bp_hold_data", m_data_o, {32'h200 ^ 32'hDEADBEEF, ~32'h200, 32'h200});
        applyStimulus(1'b1, 32'h202, 1'b1, 1'b0, 1'b0);
        checkOutput("bp_skid_to_main", m_instr_o, 32'h201);
        applyStimulus(1'b1, 32'h202, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("bp_count", dutEmitted.size(), 3);
        for (int i = 0; i < 3 && i < dutEmitted.size(); i++) begin
            checkOutput("bp_order", dutEmitted[i], 32'h200 + i);
        end

        // Flush while full, with a new entry offered in the flush cycle.
        dutEmitted.delete();
        applyStimulus(1'b1, 32'h2F0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h2F1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h300, 1'b0, 1'b1, 1'b0);
        checkOutput("fl_valid", m_valid_o, 1'b0);
        checkOutput("fl_ctrl", m_ctrl_o, 8'h00);
        checkOutput("fl_instr", m_instr_o, 32'h00000013);
        checkOutput("fl_ready", s_ready_o, 1'b1);
        checkOutput("fl_data", m_data_o, 96'h0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("fl_none_emitted", dutEmitted.size(), 0);

        // Randomised valid/ready traffic, 1000 entries.
        dutEmitted.delete();
        base = accCount;
        cyc  = 0;
        while ((accCount - base) < 1000 && cyc < 20000) begin
            applyStimulus(($urandom_range(0, 3) != 0), 32'h1000 + (accCount - base),
                          ($urandom_range(0, 2) != 0), 1'b0, 1'b0);
            cyc++;
        end
        cyc = 0;
        while (dutEmitted.size() < 1000 && cyc < 20) begin
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
            cyc++;
        end
        checkOutput("rand_count", dutEmitted.size(), 1000);
        for (int i = 0; i < 1000 && i < dutEmitted.size(); i++) begin
            checkOutput("rand_order", dutEmitted[i], 32'h1000 + i);
        end

`ifdef PIPE_SKID_STAGE_STATS_EN
        // Counter behaviour: five stalled cycles, one flush with an entry held.
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h400, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        checkOutput("st_stall", stall_cnt_o, 16'd5);
        checkOutput("st_flush", flush_cnt_o, 16'd1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        checkOutput("st_flush_kept", flush_cnt_o, 16'd1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        checkOutput("st_rst_stall", stall_cnt_o, 16'd0);
        checkOutput("st_rst_flush", flush_cnt_o, 16'd0);
`endif

        compareEn = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
